// File: rtl/quadrature_decoder.sv
// Quadrature (A,B) decoder: synchronises and glitch-filters both channels, then
// tracks the Gray sequence with x4 decoding into a wrapping position count.
module quadrature_decoder #(
  parameter int COUNT_WIDTH   = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   A,
  input  logic                   B,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   dir,
  output logic                   step,
  output logic                   err,
  output logic [1:0]             ab_state
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int IW = $clog2(SYNC_STAGES + 2);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          initCnt_q, initCnt_d;
  logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][FW-1:0]     filtCnt_q, filtCnt_d;
  logic [1:0]             prev_q, prev_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic [1:0]             synced;

  assign synced = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      initCnt_q <= '0;
      syncA_q   <= '0;
      syncB_q   <= '0;
      filt_q    <= '0;
      filtCnt_q <= '0;
      prev_q    <= '0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
      syncA_q   <= {syncA_q[SYNC_STAGES-2:0], A};
      syncB_q   <= {syncB_q[SYNC_STAGES-2:0], B};
      filt_q    <= filt_d;
      filtCnt_q <= filtCnt_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    filt_d    = filt_q;
    filtCnt_d = filtCnt_q;
    prev_d    = filt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      // Stay long enough that prev has caught up with the loaded filter value,
      // so whatever level the inputs hold at release never looks like a step.
      S_INIT: begin
        filt_d    = synced;
        filtCnt_d = '0;
        if (initCnt_q == IW'(SYNC_STAGES + 1)) begin
          state_d = S_TRACK;
        end else begin
          initCnt_d = initCnt_q + IW'(1);
        end
      end
      S_TRACK: begin
        for (int i = 0; i < 2; i++) begin
          if (synced[i] != filt_q[i]) begin
            if (filtCnt_q[i] == FW'(FILTER_CYCLES - 1)) begin
              filt_d[i]    = synced[i];
              filtCnt_d[i] = '0;
            end else begin
              filtCnt_d[i] = filtCnt_q[i] + FW'(1);
            end
          end else begin
            filtCnt_d[i] = '0;
          end
        end
        case ({prev_q, filt_q})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
            count_d = count_q + COUNT_WIDTH'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
          end
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
            count_d = count_q - COUNT_WIDTH'(1);
            dir_d   = 1'b0;
            step_d  = 1'b1;
          end
          4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = S_INIT;
    endcase
    if (clear) begin
      count_d = '0;
    end
  end

  assign count    = count_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign err      = err_q;
  assign ab_state = filt_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: a windowed-filter/Gray-index model
// compared every cycle, plus hand-computed checkpoints for each scenario.
module tb_quadrature_decoder;

  localparam int SYNC = 2;
  localparam int FILT = 2;
  localparam int HLEN = SYNC + FILT;

  logic        clk, rst, A, B, clear;
  logic [15:0] count;
  logic        dir, step, err;
  logic [1:0]  ab_state;

  quadrature_decoder #(.COUNT_WIDTH(16), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .clear(clear),
    .count(count), .dir(dir), .step(step), .err(err), .ab_state(ab_state)
  );

  int tests = 0;
  int fails = 0;
  int stepSeen = 0;
  int errSeen = 0;

  bit          modelActive = 0;
  logic [1:0]  hist [HLEN];
  logic [1:0]  mFilt, mPrev;
  logic [15:0] mCount;
  logic        mDir, mStep, mErr;

  initial clk = 0;
  always #5 clk = ~clk;

  // Position of a filtered level around the clockwise cycle 00,10,11,01.
  function automatic int gIdx(logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // A channel level is accepted once the last FILT synchronised samples agree;
  // the decoder acts one edge later on the difference of successive levels.
  always @(posedge clk) begin : modelBlk
    logic [1:0] nf;
    int d;
    bit same;
    if (modelActive) begin
      for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {A, B};
      mStep = 0;
      mErr  = 0;
      d = (gIdx(mFilt) - gIdx(mPrev) + 4) % 4;
      if (d == 1) begin
        mCount = mCount + 16'd1; mDir = 1; mStep = 1;
      end else if (d == 3) begin
        mCount = mCount - 16'd1; mDir = 0; mStep = 1;
      end else if (d == 2) begin
        mErr = 1;
      end
      if (clear) mCount = 16'd0;
      mPrev = mFilt;
      nf = mFilt;
      for (int ch = 0; ch < 2; ch++) begin
        same = 1;
        for (int k = SYNC; k < HLEN; k++) if (hist[k][ch] != hist[SYNC][ch]) same = 0;
        if (same) nf[ch] = hist[SYNC][ch];
      end
      mFilt = nf;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (step) stepSeen++;
      if (err) errSeen++;
    end
    if (modelActive && !rst) begin
      tests++;
      if (count !== mCount || dir !== mDir || step !== mStep || err !== mErr || ab_state !== mFilt) begin
        fails++;
        $display("[TB] FAIL cycle t=%0t: got count=%h dir=%b step=%b err=%b ab=%b, expected count=%h dir=%b step=%b err=%b ab=%b",
                 $time, count, dir, step, err, ab_state, mCount, mDir, mStep, mErr, mFilt);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic activateModel(input logic [1:0] lvl, input logic [15:0] cnt, input logic d);
    for (int i = 0; i < HLEN; i++) hist[i] = lvl;
    mFilt = lvl; mPrev = lvl; mCount = cnt; mDir = d; mStep = 0; mErr = 0;
    modelActive = 1;
  endtask

  task automatic applyStimulus(input logic [1:0] ab, input int holdCycles);
    @(posedge clk); #2;
    {A, B} = ab;
    repeat (holdCycles - 1) @(posedge clk);
  endtask

  task automatic pulseClear();
    @(posedge clk); #2 clear = 1;
    @(posedge clk); #2 clear = 0;
    repeat (3) @(posedge clk);
  endtask

  int s0, e0;

  initial begin
    rst = 1; A = 0; B = 0; clear = 0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_count", 32'(count), 32'h0);
    checkOutput("reset_flags", 32'({dir, step, err, ab_state}), 32'h0);
    rst = 0;
    repeat (12) @(posedge clk);
    #2;
    checkOutput("release_count", 32'(count), 32'h0);
    activateModel(2'b00, 16'h0, 1'b0);

    // 1: eight clockwise steps
    s0 = stepSeen; e0 = errSeen;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(2'b10, 10); applyStimulus(2'b11, 10);
      applyStimulus(2'b01, 10); applyStimulus(2'b00, 10);
    end
    #1;
    checkOutput("cw8_count", 32'(count), 32'd8);
    checkOutput("cw8_dir", 32'(dir), 32'd1);
    checkOutput("cw8_steps", 32'(stepSeen - s0), 32'd8);
    checkOutput("cw8_err", 32'(errSeen - e0), 32'd0);

    // 2: wrap below zero and back
    pulseClear();
    checkOutput("clear_count", 32'(count), 32'h0);
    applyStimulus(2'b01, 10); applyStimulus(2'b11, 10); applyStimulus(2'b10, 10);
    #1;
    checkOutput("ccw3_count", 32'(count), 32'hFFFD);
    checkOutput("ccw3_dir", 32'(dir), 32'd0);
    applyStimulus(2'b11, 10); applyStimulus(2'b01, 10); applyStimulus(2'b00, 10);
    #1;
    checkOutput("cw3_count", 32'(count), 32'h0);
    checkOutput("cw3_dir", 32'(dir), 32'd1);

    // 3: one-cycle glitch rejected, two-cycle level accepted at E+4
    s0 = stepSeen;
    @(posedge clk); #2 A = 1;
    @(posedge clk); #2 A = 0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("glitch_ab", 32'(ab_state), 32'h0);
    checkOutput("glitch_count", 32'(count), 32'h0);
    checkOutput("glitch_steps", 32'(stepSeen - s0), 32'd0);
    #1 A = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("lat_step_E3", 32'(step), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("lat_step_E4", 32'(step), 32'd1);
    checkOutput("lat_count_E4", 32'(count), 32'd1);
    repeat (6) @(posedge clk);

    // 4: both channels change together
    applyStimulus(2'b00, 10);
    e0 = errSeen;
    applyStimulus(2'b11, 10);
    #1;
    checkOutput("err_pulses", 32'(errSeen - e0), 32'd1);
    checkOutput("err_count", 32'(count), 32'h0);
    checkOutput("err_ab", 32'(ab_state), 32'h3);
    applyStimulus(2'b01, 10);
    #1;
    checkOutput("after_err_count", 32'(count), 32'd1);

    // 5: clear coinciding with a step
    applyStimulus(2'b00, 10); applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10); applyStimulus(2'b01, 10);
    #1;
    checkOutput("pre_clear_count", 32'(count), 32'd5);
    @(posedge clk); #2 {A, B} = 2'b00;
    repeat (4) @(posedge clk);
    #2 clear = 1;
    @(posedge clk); #2 clear = 0;
    @(negedge clk);
    checkOutput("clrstep_count", 32'(count), 32'h0);
    checkOutput("clrstep_step", 32'(step), 32'd1);
    checkOutput("clrstep_dir", 32'(dir), 32'd1);
    repeat (8) @(posedge clk);

    // 6: reset mid-rotation at count 7 with A=B=1
    applyStimulus(2'b01, 10);
    pulseClear();
    applyStimulus(2'b00, 10); applyStimulus(2'b10, 10); applyStimulus(2'b11, 10);
    applyStimulus(2'b01, 10); applyStimulus(2'b00, 10); applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    #1;
    checkOutput("pre_rst_count", 32'(count), 32'd7);
    @(posedge clk); #2;
    modelActive = 0;
    rst = 1;
    #1;
    checkOutput("midrst_count", 32'(count), 32'h0);
    checkOutput("midrst_flags", 32'({dir, step, err, ab_state}), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    s0 = stepSeen; e0 = errSeen;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("rel_ab", 32'(ab_state), 32'h3);
    checkOutput("rel_count", 32'(count), 32'h0);
    checkOutput("rel_quiet", 32'((errSeen - e0) + (stepSeen - s0)), 32'd0);
    activateModel(2'b11, 16'h0, 1'b0);
    applyStimulus(2'b01, 10);
    #1;
    checkOutput("post_rst_step", 32'(count), 32'd1);
    modelActive = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
